// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory port between instruction
// fetch (read-only) and the LSU (read/write). One transaction is outstanding at
// a time; each is bounded by a response timeout that completes it with an error.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, ties in IDLE go to the
// requester that was not served last instead of fixed LSU-over-IF priority.
module mem_port_arbiter #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_rvalid_o,
   output logic [XLEN-1:0] if_rdata_o,
   output logic            if_err_o,
   output logic            if_stall_o,
   input  logic            lsu_req_i,
   input  logic            lsu_we_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   input  logic [1:0]      lsu_size_i,
   output logic            lsu_rvalid_o,
   output logic [XLEN-1:0] lsu_rdata_o,
   output logic            lsu_err_o,
   output logic            lsu_stall_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [1:0]      mem_size_o,
   input  logic            mem_ready_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam logic             OWN_IF   = 1'b0;
   localparam logic             OWN_LSU  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_r;
   state_t            next_state_s;
   logic              grant_lsu_s;
   logic              any_req_s;
   logic              owner_r;
   logic              we_r;
   logic [XLEN-1:0]   addr_r;
   logic [XLEN-1:0]   wdata_r;
   logic [1:0]        size_r;
   logic [XLEN-1:0]   rdata_r;
   logic              err_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              in_issue_s;
   logic              in_resp_s;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_owner_r;
`endif

   assign any_req_s = if_req_i | lsu_req_i;

   // Pick the winner among pending requesters while idle.
   always_comb begin
      grant_lsu_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (lsu_req_i && if_req_i) begin
         grant_lsu_s = (last_owner_r == OWN_IF);
      end else begin
         grant_lsu_s = lsu_req_i;
      end
`else
      grant_lsu_s = lsu_req_i;
`endif
   end

   // Next-state logic for the transaction FSM.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) next_state_s = ISSUE;
            else           next_state_s = IDLE;
         end
         ISSUE: begin
            if (mem_ready_i && mem_rvalid_i) next_state_s = RESP;
            else if (mem_ready_i)            next_state_s = WAIT_RSP;
            else                             next_state_s = ISSUE;
         end
         WAIT_RSP: begin
            if (mem_rvalid_i)            next_state_s = RESP;
            else if (cnt_r == CNT_LAST)  next_state_s = RESP;
            else                         next_state_s = WAIT_RSP;
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock_i) begin
      if (reset_i) state_r <= IDLE;
      else         state_r <= next_state_s;
   end

   // Latch the granted request, capture responses and run the timeout counter.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         owner_r <= OWN_IF;
         we_r    <= 1'b0;
         addr_r  <= {XLEN{1'b0}};
         wdata_r <= {XLEN{1'b0}};
         size_r  <= 2'b00;
         rdata_r <= {XLEN{1'b0}};
         err_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  owner_r <= grant_lsu_s ? OWN_LSU : OWN_IF;
                  if (grant_lsu_s) begin
                     we_r    <= lsu_we_i;
                     addr_r  <= lsu_addr_i;
                     wdata_r <= lsu_we_i ? lsu_wdata_i : {XLEN{1'b0}};
                     size_r  <= lsu_size_i;
                  end else begin
                     we_r    <= 1'b0;
                     addr_r  <= if_addr_i;
                     wdata_r <= {XLEN{1'b0}};
                     size_r  <= 2'b10;
                  end
               end
            end
            ISSUE: begin
               cnt_r <= {CNT_W{1'b0}};
               if (mem_ready_i && mem_rvalid_i) begin
                  rdata_r <= mem_rdata_i;
                  err_r   <= 1'b0;
               end
            end
            WAIT_RSP: begin
               if (mem_rvalid_i) begin
                  rdata_r <= mem_rdata_i;
                  err_r   <= 1'b0;
               end else if (cnt_r == CNT_LAST) begin
                  rdata_r <= {XLEN{1'b0}};
                  err_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember who was served last so the other side wins the next tie.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         last_owner_r <= OWN_LSU;
      end else if ((state_r != RESP) && (next_state_s == RESP)) begin
         last_owner_r <= owner_r;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end
`endif

   // Outputs are decoded straight from registered state; stalls follow the requests.
   assign in_issue_s   = (state_r == ISSUE);
   assign in_resp_s    = (state_r == RESP);
   assign mem_req_o    = in_issue_s;
   assign mem_we_o     = in_issue_s & we_r;
   assign mem_addr_o   = in_issue_s ? addr_r  : {XLEN{1'b0}};
   assign mem_wdata_o  = in_issue_s ? wdata_r : {XLEN{1'b0}};
   assign mem_size_o   = in_issue_s ? size_r  : 2'b00;
   assign if_rvalid_o  = in_resp_s & (owner_r == OWN_IF);
   assign lsu_rvalid_o = in_resp_s & (owner_r == OWN_LSU);
   assign if_err_o     = if_rvalid_o & err_r;
   assign lsu_err_o    = lsu_rvalid_o & err_r;
   assign if_rdata_o   = rdata_r;
   assign lsu_rdata_o  = rdata_r;
   assign if_stall_o   = if_req_i & ~if_rvalid_o;
   assign lsu_stall_o  = lsu_req_i & ~lsu_rvalid_o;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF, read-only) and the execute stage's load/store path (LSU, read/write).
- Sits between the fetch/execute stages and the memory interface.
- Produces the per-requester stall signals that drive the fetch stall and the execute unit's mem_stall_i.
- Handles one outstanding transaction at a time; bounds each transaction with a response timeout.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before the transaction is aborted with error; must be at least 1.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous reset, active-high.
- if_req_i  in  1  fetch request; held until if_rvalid_o.
- if_addr_i  in  XLEN  fetch address.
- if_rvalid_o  out  1  fetch response, single-cycle pulse.
- if_rdata_o  out  XLEN  fetch read data.
- if_err_o  out  1  fetch timeout error, qualified by if_rvalid_o.
- if_stall_o  out  1  fetch stall.
- lsu_req_i  in  1  LSU request; held with stable fields until lsu_rvalid_o.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_addr_i  in  XLEN  LSU address.
- lsu_wdata_i  in  XLEN  store data.
- lsu_size_i  in  2  00 = byte, 01 = half, 10 = word.
- lsu_rvalid_o  out  1  LSU response, single-cycle pulse.
- lsu_rdata_o  out  XLEN  load data.
- lsu_err_o  out  1  LSU timeout error, qualified by lsu_rvalid_o.
- lsu_stall_o  out  1  LSU stall; drives the execute unit's mem_stall_i.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  XLEN  memory address.
- mem_wdata_o  out  XLEN  memory write data.
- mem_size_o  out  2  memory access size.
- mem_ready_i  in  1  memory accepts the request when mem_req_o & mem_ready_i.
- mem_rvalid_i  in  1  memory response; stores are also acknowledged.
- mem_rdata_i  in  XLEN  memory read data.

Behaviour:

FSM states:
- IDLE
- ISSUE: mem_req_o = 1, driven from latched request fields.
- WAIT_RSP
- RESP: one cycle; the owner's rvalid is high.

State transitions:
- IDLE: if any request is pending, latch the winner's fields and owner bit, then go to ISSUE. Arbitration is combinational in IDLE; mem_req_o rises one cycle after the request is seen.
- Priority: LSU beats IF when both are requesting (the older instruction drains first).
- ISSUE: hold all mem_* outputs stable until mem_ready_i. On acceptance, go to WAIT_RSP with the timeout counter at 0.
- mem_ready_i and mem_rvalid_i in the same cycle while in ISSUE: capture the data and go directly to RESP.
- WAIT_RSP: on mem_rvalid_i, capture mem_rdata_i, clear the error flag, go to RESP. Otherwise increment the counter.
- Timeout: when the counter reaches TIMEOUT_CYCLES - 1 with no mem_rvalid_i, go to RESP with data 0 and the error flag set.
- RESP: pulse the owner's rvalid for exactly one cycle, then return to IDLE.
- Minimum transaction: 4 cycles from request to rvalid (request seen, ISSUE with ready=1, WAIT_RSP with rvalid=1, RESP).
- The non-owner's rvalid stays 0 throughout.
- if_rdata_o and lsu_rdata_o both show the captured response register; each is qualified only by its own rvalid.
- mem_wdata_o is 0 for loads and for fetches. mem_we_o is 0 for fetches. mem_size_o is 10 for fetches.

Stalls:
- if_stall_o = if_req_i & ~if_rvalid_o.
- lsu_stall_o = lsu_req_i & ~lsu_rvalid_o.

Other rules:
- Requests dropped before their grant are ignored.
- A request that drops after its grant still completes; its response pulse is then ignored by the requester.
- mem_rvalid_i outside WAIT_RSP (and outside ISSUE with ready) is ignored.
- Reset mid-transaction: FSM returns to IDLE and the in-flight response is discarded.
- Reset values: all outputs 0 except the stalls, which follow their equations. FSM = IDLE, counter = 0, data register = 0, owner = IF.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register is added, updated on entry to RESP. When both requesters are pending in IDLE, the non-last owner wins; this prevents fetch starvation under back-to-back loads. The last-owner register resets to LSU, so IF wins the first tie.
- Undefined: fixed LSU-over-IF priority and no extra register.

Test Plan:
- Single LSU load: lsu_req_i=1, lsu_we_i=0, lsu_addr_i=0x100, mem_ready_i=1, mem_rvalid_i=1 with rdata 0xDEADBEEF one cycle after acceptance -> mem_req_o high exactly 1 cycle with addr 0x100; lsu_rvalid_o one-cycle pulse with lsu_rdata_o=0xDEADBEEF, lsu_err_o=0; lsu_stall_o high until that pulse; if_rvalid_o stays 0.
- Collision: if_req_i and lsu_req_i rise together (IF addr 0x0, LSU store to 0x200 with data 0x55, size 00) -> LSU served first (mem_we_o=1, mem_size_o=00); IF issued only after the LSU RESP cycle; if_stall_o high throughout; with ARB_ROUND_ROBIN_EN, IF is served first instead.
- Backpressure: mem_ready_i low for 3 cycles during ISSUE -> mem_addr_o, mem_we_o, mem_wdata_o and mem_size_o stable for all 4 ISSUE cycles; no response before acceptance.
- Timeout: TIMEOUT_CYCLES=4, mem_rvalid_i never asserted -> rvalid pulse with err=1 and rdata=0 after exactly 4 WAIT_RSP cycles; the next request is served normally.
- Reset mid-operation: reset_i=1 for 1 cycle while in WAIT_RSP -> all outputs 0 on the next cycle; a later mem_rvalid_i is ignored; the held request is re-issued from IDLE.
- Back-to-back fetches: if_req_i held across 3 addresses 0x0, 0x4, 0x8 with ready=1 and rvalid=1 -> three if_rvalid_o pulses, spaced 4 cycles apart, each with the correct data.
